mcc2x2_drain: RTL and testbench
===============================

# mcc2x2_drain

Partial-sum drain for the 2x2 MAC cluster. On a capture strobe it samples the four 26-bit accumulator outputs of one cluster, requantizes each to 16 bits (arithmetic shift, saturation, optional ReLU) and writes them one per beat over a valid/ready port to the output-feature-map buffer at consecutive addresses. It sits between the cluster outputs and the output SRAM writer, freeing the cluster to start its next accumulation immediately after capture.

## Interface
- PSUM_W, 26: partial-sum width, two's complement
- OUT_W, 16: requantized output width, two's complement
- ADDR_W, 10: output buffer address width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- i_capture  in  1  one-cycle strobe: psums valid, sample them
- i_psum0..i_psum3  in  PSUM_W each  cluster outputs (i0w0, i0w1, i1w0, i1w1)
- i_shift  in  5  right-shift amount, 0..25, sampled with i_capture
- i_base_addr  in  ADDR_W  write address of psum0, sampled with i_capture
- o_busy  out  1  high in SEND and DONE; capture ignored while high
- o_wr_valid  out  1  write beat valid
- i_wr_ready  in  1  buffer accepts beat
- o_wr_addr  out  ADDR_W  beat address
- o_wr_data  out  OUT_W  requantized beat data
- o_done  out  1  one-cycle pulse after 4th beat accepted

## Operation
- States: IDLE, SEND, DONE.
- IDLE: i_capture=1 -> register 4 psums, shift, base addr; idx<=0; go SEND.
- SEND: o_wr_valid=1, o_wr_data=requant(psum[idx]), o_wr_addr=(base+idx) mod 2^ADDR_W. Beat accepted when valid&&ready: idx 0..2 -> idx+1; idx 3 -> DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- Requant: arithmetic shift right of signed psum by shift (truncation toward -inf), then saturate to [-32768, 32767].
- i_capture in SEND or DONE: ignored, no state change, held data unaffected.
- Address wraps modulo 2^ADDR_W.
- Reset asserted at any time: immediately IDLE, idx=0, held psums discarded, no further beats or o_done.

## Timing
- Reset values: o_busy=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_done=0.
- o_wr_data/o_wr_addr registered from held state; combinational from i_wr_ready: none.
- Capture at edge N -> first beat valid in cycle N+1.
- Ready always high: beats in N+1..N+4, o_done in N+5, IDLE (capture accepted) from N+6.
- Each cycle of ready low while valid adds one cycle; data and address held stable, valid never drops mid-transfer.
- Inputs i_psum*/i_shift/i_base_addr only sampled on accepted capture.

## Configuration
- DRAIN_RELU_EN defined: after saturation, negative results forced to 0 (range 0..32767).
- Undefined: signed saturated value passed through unchanged.

## Structure
- Shared package mcc_pkg: PSUM_W, OUT_W defaults, drain state encoding (IDLE/SEND/DONE), shift-width constant.
- One sub-module: mcc_requant, combinational shift/saturate/ReLU of one psum, instantiated once on the mux output selected by idx.

## Test plan
- Basic: shift=0, psums 100, -5, 32767, 0, base=8, ready=1 -> data 0x0064, 0xFFFB, 0x7FFF, 0x0000 at addr 8..11 in N+1..N+4, o_done at N+5.
- Saturation/shift: psum 0x1FFFFFF with shift=4 -> 0x7FFF; psum 0x2000000 with shift=0 -> 0x8000; psum 0x0001000 with shift=4 -> 0x0100.
- Backpressure: ready low 3 cycles during beat 1 -> addr/data held constant, valid stays 1, o_done at N+8.
- Wrap: base=1022 -> addresses 1022, 1023, 0, 1.
- Capture while busy and reset mid-SEND: second capture during beat 2 ignored (original data completes); reset asserted during beat 2 -> o_wr_valid=0 and o_busy=0 immediately, no o_done.
- DRAIN_RELU_EN build: psum -5 -> 0x0000, psum 100 -> 0x0064.

Source files
------------

// File: rtl/mcc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : mcc_pkg                                                |
// | Description : Shared constants for the 2x2 MAC cluster drain:        |
// |               default widths, shift-amount width, drain FSM state    |
// |               encoding.                                              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package mcc_pkg;

  localparam int C_PSUM_W  = 26;  // accumulator width, two's complement
  localparam int C_OUT_W   = 16;  // requantized width, two's complement
  localparam int C_ADDR_W  = 10;  // output buffer address width
  localparam int C_SHIFT_W = 5;   // right-shift amount field, 0..25

  // Drain FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mcc2x2_drain_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : mcc2x2_drain_if                                        |
// | Description : Valid/ready write port from the drain to the output    |
// |               feature-map buffer.                                    |
// |   o_wr_valid  drain -> buffer  write beat valid                      |
// |   i_wr_ready  buffer -> drain  buffer accepts beat                   |
// |   o_wr_addr   drain -> buffer  beat address (ADDR_W)                 |
// |   o_wr_data   drain -> buffer  requantized beat data (OUT_W)         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface mcc2x2_drain_if #(
  parameter int ADDR_W = 10,
  parameter int OUT_W  = 16
);
  logic              o_wr_valid;
  logic              i_wr_ready;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [OUT_W-1:0]  o_wr_data;

  // Drain side
  modport master (
    output o_wr_valid,
    output o_wr_addr,
    output o_wr_data,
    input  i_wr_ready
  );

  // Buffer side
  modport slave (
    input  o_wr_valid,
    input  o_wr_addr,
    input  o_wr_data,
    output i_wr_ready
  );
endinterface
`default_nettype wire

// File: rtl/mcc_requant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mcc_requant                                            |
// | Description : Combinational requantizer for one partial sum:         |
// |               arithmetic right shift (toward -inf), saturation to    |
// |               OUT_W signed, optional ReLU.                           |
// |   i_psum   PSUM_W signed partial sum                                 |
// |   i_shift  shift amount                                              |
// |   o_data   OUT_W requantized value                                   |
// | Config      : DRAIN_RELU_EN defined -> negative results clamp to 0   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mcc_requant
  import mcc_pkg::*;
#(
  parameter int PSUM_W = C_PSUM_W,
  parameter int OUT_W  = C_OUT_W
) (
  input  logic signed [PSUM_W-1:0]    i_psum,
  input  logic        [C_SHIFT_W-1:0] i_shift,
  output logic        [OUT_W-1:0]     o_data
);

  localparam logic [OUT_W-1:0] C_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] C_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [PSUM_W-1:0]       w_shifted;
  logic        [PSUM_W-OUT_W:0]   w_hi;
  logic                           w_fits;
  logic        [OUT_W-1:0]        w_sat;

  assign w_shifted = i_psum >>> i_shift;

  // Value fits in OUT_W iff all bits from the OUT_W sign bit upward agree.
  assign w_hi   = w_shifted[PSUM_W-1:OUT_W-1];
  assign w_fits = (&w_hi) | ~(|w_hi);

  always_comb begin
    if (w_fits) begin
      w_sat = w_shifted[OUT_W-1:0];
    end else if (w_shifted[PSUM_W-1]) begin
      w_sat = C_MIN;
    end else begin
      w_sat = C_MAX;
    end
  end

`ifdef DRAIN_RELU_EN
  assign o_data = w_sat[OUT_W-1] ? '0 : w_sat;
`else
  assign o_data = w_sat;
`endif

endmodule
`default_nettype wire

// File: rtl/mcc2x2_drain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mcc2x2_drain                                           |
// | Description : Partial-sum drain for the 2x2 MAC cluster. Captures    |
// |               four psums on i_capture, requantizes them and writes   |
// |               them one per beat to base..base+3 (mod 2^ADDR_W).      |
// |   clk, reset       clock / asynchronous active-low reset             |
// |   i_capture        one-cycle capture strobe (ignored while busy)     |
// |   i_psum0..3       cluster outputs i0w0, i0w1, i1w0, i1w1            |
// |   i_shift          right-shift amount, sampled with capture          |
// |   i_base_addr      address of psum0, sampled with capture            |
// |   o_busy           high in SEND and DONE                             |
// |   o_done           one-cycle pulse after the 4th beat                |
// |   wr_if            valid/ready write port (master)                   |
// | Config      : DRAIN_RELU_EN (see mcc_requant)                        |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mcc2x2_drain
  import mcc_pkg::*;
#(
  parameter int PSUM_W = C_PSUM_W,
  parameter int OUT_W  = C_OUT_W,
  parameter int ADDR_W = C_ADDR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_capture,
  input  logic signed [PSUM_W-1:0]    i_psum0,
  input  logic signed [PSUM_W-1:0]    i_psum1,
  input  logic signed [PSUM_W-1:0]    i_psum2,
  input  logic signed [PSUM_W-1:0]    i_psum3,
  input  logic        [C_SHIFT_W-1:0] i_shift,
  input  logic        [ADDR_W-1:0]    i_base_addr,
  output logic                        o_busy,
  output logic                        o_done,
  mcc2x2_drain_if.master              wr_if
);

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [1:0]               r_idx;
  logic signed [PSUM_W-1:0] r_psum [4];
  logic [C_SHIFT_W-1:0]     r_shift;
  logic [ADDR_W-1:0]        r_base;
  logic                     w_capture;
  logic                     w_beat;
  logic [OUT_W-1:0]         w_rq;

  assign w_capture = (r_state == ST_IDLE) && i_capture;
  assign w_beat    = (r_state == ST_SEND) && wr_if.i_wr_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_capture) w_state_nxt = ST_SEND;
      ST_SEND: if (wr_if.i_wr_ready && (r_idx == 2'd3)) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Held capture data and beat index; cleared on reset so nothing survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= 2'd0;
      r_shift <= '0;
      r_base  <= '0;
      for (int i = 0; i < 4; i++) r_psum[i] <= '0;
    end else if (w_capture) begin
      r_idx     <= 2'd0;
      r_shift   <= i_shift;
      r_base    <= i_base_addr;
      r_psum[0] <= i_psum0;
      r_psum[1] <= i_psum1;
      r_psum[2] <= i_psum2;
      r_psum[3] <= i_psum3;
    end else if (w_beat && (r_idx != 2'd3)) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  // Single requantizer on the beat mux output
  mcc_requant #(
    .PSUM_W (PSUM_W),
    .OUT_W  (OUT_W)
  ) u_requant (
    .i_psum  (r_psum[r_idx]),
    .i_shift (r_shift),
    .o_data  (w_rq)
  );

  // Outputs: all derived from held state only; address/data forced to 0
  // outside SEND so idle outputs match the reset values.
  always_comb begin
    o_busy           = (r_state == ST_SEND) || (r_state == ST_DONE);
    o_done           = (r_state == ST_DONE);
    wr_if.o_wr_valid = (r_state == ST_SEND);
    wr_if.o_wr_addr  = '0;
    wr_if.o_wr_data  = '0;
    if (r_state == ST_SEND) begin
      wr_if.o_wr_addr = r_base + ADDR_W'(r_idx);
      wr_if.o_wr_data = w_rq;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcc2x2_drain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mcc2x2_drain                                        |
// | Description : Self-checking bench for mcc2x2_drain. Expected beats   |
// |               are queued at capture and popped on accepted beats.    |
// | Config      : DRAIN_RELU_EN changes the requant model accordingly    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_mcc2x2_drain;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        i_capture;
  logic [25:0] i_psum0, i_psum1, i_psum2, i_psum3;
  logic [4:0]  i_shift;
  logic [9:0]  i_base_addr;
  logic        o_busy;
  logic        o_done;

  mcc2x2_drain_if #(.ADDR_W(10), .OUT_W(16)) wr_if ();

  mcc2x2_drain u_dut (
    .clk         (clk),
    .reset       (reset),
    .i_capture   (i_capture),
    .i_psum0     (i_psum0),
    .i_psum1     (i_psum1),
    .i_psum2     (i_psum2),
    .i_psum3     (i_psum3),
    .i_shift     (i_shift),
    .i_base_addr (i_base_addr),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .wr_if       (wr_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference requantizer
  function automatic logic [15:0] f_requant(input logic [25:0] p, input int sh);
    longint v;
    v = longint'($signed(p));
    v = v >>> sh;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`ifdef DRAIN_RELU_EN
    if (v < 0) v = 0;
`endif
    return v[15:0];
  endfunction

  // Beat monitor: pops the scoreboard on every accepted beat and checks
  // that a stalled beat stays valid and stable into the next cycle.
  logic        r_hold_chk = 1'b0;
  logic [9:0]  r_hold_addr;
  logic [15:0] r_hold_data;
  always @(negedge clk) begin
    beat_t b;
    if (r_hold_chk && reset) begin
      chk("hold_valid", 32'(wr_if.o_wr_valid), 32'd1);
      chk("hold_addr",  32'(wr_if.o_wr_addr),  32'(r_hold_addr));
      chk("hold_data",  32'(wr_if.o_wr_data),  32'(r_hold_data));
    end
    r_hold_chk  = wr_if.o_wr_valid && !wr_if.i_wr_ready && reset;
    r_hold_addr = wr_if.o_wr_addr;
    r_hold_data = wr_if.o_wr_data;
    if (wr_if.o_wr_valid && wr_if.i_wr_ready) begin
      if (sb.size() == 0) begin
        chk("extra_beat", 32'd1, 32'd0);
      end else begin
        b = sb.pop_front();
        chk("beat_addr", 32'(wr_if.o_wr_addr), 32'(b.addr));
        chk("beat_data", 32'(wr_if.o_wr_data), 32'(b.data));
      end
    end
  end

  // Drive one capture (sampled at the next rising edge) and queue its beats.
  task automatic do_capture(input logic [25:0] p0, input logic [25:0] p1,
                            input logic [25:0] p2, input logic [25:0] p3,
                            input int sh, input int base);
    logic [25:0] p [4];
    beat_t b;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    i_psum0 = p0; i_psum1 = p1; i_psum2 = p2; i_psum3 = p3;
    i_shift = 5'(sh);
    i_base_addr = 10'(base);
    i_capture = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b.addr = 10'((base + i) % 1024);
      b.data = f_requant(p[i], sh);
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
    i_capture = 1'b0;
  endtask

  // Runs cycles after a capture until o_done; stall_mask bit n drops ready
  // in cycle N+n; recap_at > 0 asserts a junk capture in that cycle.
  task automatic run_until_done(input string tag, input int exp_cyc,
                                input logic [63:0] stall_mask, input int recap_at);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      n++;
      wr_if.i_wr_ready = !stall_mask[n];
      if (n == recap_at) begin
        i_capture = 1'b1;
        i_psum0 = 26'd7; i_psum1 = 26'd7; i_psum2 = 26'd7; i_psum3 = 26'd7;
        i_shift = 5'd0;  i_base_addr = 10'd500;
      end else begin
        i_capture = 1'b0;
      end
      @(negedge clk);
      if (n == 1) chk({tag, "_busy"}, 32'(o_busy), 32'd1);
      if (o_done) seen = 1;
      @(posedge clk);
      #1;
    end
    i_capture = 1'b0;
    wr_if.i_wr_ready = 1'b1;
    chk({tag, "_done_cycle"}, 32'(n), 32'(exp_cyc));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk({tag, "_idle"}, 32'(o_busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done_cnt;
    reset = 1'b0;
    i_capture = 1'b0;
    i_psum0 = '0; i_psum1 = '0; i_psum2 = '0; i_psum3 = '0;
    i_shift = '0;
    i_base_addr = '0;
    wr_if.i_wr_ready = 1'b1;
    #3;
    chk("rst_busy",  32'(o_busy),           32'd0);
    chk("rst_valid", 32'(wr_if.o_wr_valid), 32'd0);
    chk("rst_addr",  32'(wr_if.o_wr_addr),  32'd0);
    chk("rst_data",  32'(wr_if.o_wr_data),  32'd0);
    chk("rst_done",  32'(o_done),           32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic: shift 0, base 8
    do_capture(26'd100, -26'sd5, 26'd32767, 26'd0, 0, 8);
    run_until_done("basic", 5, 64'h0, 0);

    // Saturation and shift
    do_capture(26'h1FFFFFF, 26'h0001000, 26'h2000000, 26'h3FFFFF0, 4, 100);
    run_until_done("sat_sh4", 5, 64'h0, 0);
    do_capture(26'h2000000, -26'sd32768, 26'd32768, -26'sd32769, 0, 200);
    run_until_done("sat_sh0", 5, 64'h0, 0);
    do_capture(26'h1FFFFFF, 26'h2000000, 26'd5, -26'sd5, 25, 300);
    run_until_done("sh25", 5, 64'h0, 0);

    // Backpressure: ready low in N+2..N+4 while beat 1 is presented
    do_capture(26'd1, 26'd2, 26'd3, 26'd4, 0, 40);
    run_until_done("bp", 8, 64'h1C, 0);

    // Address wrap
    do_capture(26'd11, 26'd22, 26'd33, 26'd44, 1, 1022);
    run_until_done("wrap", 5, 64'h0, 0);

    // Capture during beat 2 is ignored
    do_capture(26'd100, -26'sd5, 26'd1000, 26'd2000, 0, 16);
    run_until_done("recap", 5, 64'h0, 3);

    // Reset during beat 2: outputs drop at once, no further beats, no done
    do_capture(26'd100, -26'sd5, 26'd1000, 26'd2000, 0, 64);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("mid_valid_pre", 32'(wr_if.o_wr_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(wr_if.o_wr_valid), 32'd0);
    chk("mid_rst_busy",  32'(o_busy),           32'd0);
    chk("mid_rst_left",  32'(sb.size()),        32'd2);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_done) done_cnt++;
    end
    chk("mid_rst_nodone", 32'(done_cnt), 32'd0);

    // Drain still usable after the mid-transfer reset
    @(posedge clk); #1;
    do_capture(26'd9, 26'd8, 26'd7, 26'd6, 0, 0);
    run_until_done("post_rst", 5, 64'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
